cla_operand_stage: RTL and testbench

//  Valid/ready pipeline wrapped around the 15b+12b unsigned combinational CLA adder.

---
 rtl/cla_pkg.sv | 15 +
 rtl/cla_pipe_slice.sv | 41 ++++
 rtl/cla_operand_stage.sv | 90 +++++++++
 tb/tb_cla_operand_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared widths and payload types for the CLA operand pipeline.
package cla_pkg;

  localparam int CLA_XW = 15;
  localparam int CLA_YW = 12;
  localparam int CLA_SW = CLA_XW + 1;

  typedef struct packed {
    logic [CLA_XW-1:0] x;
    logic [CLA_YW-1:0] y;
  } cla_opnd_t;

  typedef logic [CLA_SW-1:0] cla_sum_t;

endpackage

// File: rtl/cla_pipe_slice.sv
// One valid/ready register slice with synchronous flush; full throughput, no bubbles.
// Handshake: a transfer happens on a rising edge where valid && ready; a source holds
// valid and data steady until that edge.
module cla_pipe_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_adv;

  // The slice may load whenever it is empty or its content leaves this cycle.
  assign w_adv   = !r_valid || i_ready;
  assign o_ready = w_adv && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (clr) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/cla_operand_stage.sv
// Two-slice valid/ready pipeline around an external combinational CLA adder.
// Optional statistics counters are built when CLA_STAGE_STATS_EN is defined.
module cla_operand_stage
  import cla_pkg::*;
#(
  parameter int XW    = CLA_XW,
  parameter int YW    = CLA_YW,
  parameter int SW    = XW + 1,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic [YW-1:0] in_y,
  output logic [XW-1:0] add_x,
  output logic [YW-1:0] add_y,
  input  logic [SW-1:0] add_s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic          out_cout
`ifdef CLA_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_txn,
  output logic [CNT_W-1:0] stat_cout
`endif
);

  localparam int OPW = XW + YW;

  logic           w_s1_valid;
  logic [OPW-1:0] w_s1_data;
  logic           w_s2_ready;

  // Operand slice: its flops drive the adder directly.
  cla_pipe_slice #(.W(OPW)) u_opnd_slice (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  ({in_x, in_y}),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_data)
  );

  assign add_x = w_s1_data[OPW-1:YW];
  assign add_y = w_s1_data[YW-1:0];

  cla_pipe_slice #(.W(SW)) u_sum_slice (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (add_s),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (out_sum)
  );

  assign out_cout = out_sum[SW-1];

`ifdef CLA_STAGE_STATS_EN
  logic [CNT_W-1:0] r_stat_txn;
  logic [CNT_W-1:0] r_stat_cout;

  // Saturating counters of completed output transfers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_txn  <= '0;
      r_stat_cout <= '0;
    end else if (clr) begin
      r_stat_txn  <= '0;
      r_stat_cout <= '0;
    end else if (out_valid && out_ready) begin
      if (r_stat_txn != '1) r_stat_txn <= r_stat_txn + CNT_W'(1);
      if (out_cout && (r_stat_cout != '1)) r_stat_cout <= r_stat_cout + CNT_W'(1);
    end
  end

  assign stat_txn  = r_stat_txn;
  assign stat_cout = r_stat_cout;
`endif

endmodule

// File: tb/tb_cla_operand_stage.sv
// Directed and random checks of cla_operand_stage with a behavioural adder on add_*.
module tb_cla_operand_stage;

  localparam int XW    = 15;
  localparam int YW    = 12;
  localparam int SW    = 16;
  localparam int CNT_W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic [YW-1:0] in_y;
  logic [XW-1:0] add_x;
  logic [YW-1:0] add_y;
  logic [SW-1:0] add_s;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic          out_cout;
`ifdef CLA_STAGE_STATS_EN
  logic [CNT_W-1:0] stat_txn;
  logic [CNT_W-1:0] stat_cout;
`endif

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] sb_exp;

  // ---------------- clock / reset / adder ----------------
  always #5 clk = ~clk;

  assign add_s = {1'b0, add_x} + {{(SW-YW){1'b0}}, add_y};

  cla_operand_stage #(.CNT_W(CNT_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_s     (add_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef CLA_STAGE_STATS_EN
    ,
    .stat_txn  (stat_txn),
    .stat_cout (stat_cout)
`endif
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: push expected sum on input handshake, pop on output handshake.
  always @(negedge clk) begin
    if (!rst && !clr) begin
      if (out_valid && out_ready) begin
        check("sb_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          sb_exp = exp_q.pop_front();
          check("sb_sum", out_sum, sb_exp);
          check("sb_cout", out_cout, sb_exp[SW-1]);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({1'b0, in_x} + {{(SW-YW){1'b0}}, in_y});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [XW-1:0] x, input logic [YW-1:0] y, input int ready_pct);
    logic acc;
    int   tries;
    in_x     = x;
    in_y     = y;
    in_valid = 1'b1;
    tries    = 0;
    do begin
      out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      acc = in_ready;
      cyc();
      tries++;
    end while (!acc && tries < 1000);
    check("send_accept", acc, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    cyc();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_add_x", add_x, 0);
    check("rst_add_y", add_y, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: back-to-back stream
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 15'd32767; in_y = 12'd4095;
    cyc();
    in_x = 15'd1; in_y = 12'd0;
    cyc();
    check("t1_valid0", out_valid, 1);
    check("t1_sum0", out_sum, 36862);
    check("t1_cout0", out_cout, 1);
    in_x = 15'd0; in_y = 12'd0;
    cyc();
    in_valid = 1'b0;
    check("t1_sum1", out_sum, 1);
    check("t1_cout1", out_cout, 0);
    cyc();
    check("t1_valid2", out_valid, 1);
    check("t1_sum2", out_sum, 0);
    cyc();
    check("t1_empty", out_valid, 0);

    // 2: full pipe held by back-pressure, then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 15'd100; in_y = 12'd200;
    cyc();
    in_x = 15'd1000; in_y = 12'd2000;
    cyc();
    in_x = 15'd7; in_y = 12'd8;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_in_ready_low", in_ready, 0);
      cyc();
      check("t2_sum_held", out_sum, 300);
    end
    out_ready = 1'b1;
    #1;
    check("t2_in_ready_high", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    check("t2_drain1", out_sum, 3000);
    cyc();
    check("t2_drain2", out_sum, 15);
    cyc();
    check("t2_empty", out_valid, 0);

    // 3: asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 15'd1; in_y = 12'd2;
    cyc();
    in_x = 15'd3; in_y = 12'd4;
    cyc();
    in_valid = 1'b0;
    check("t3_full", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("t3_rst_async", out_valid, 0);
    exp_q.delete();
    #3 rst = 1'b0;
    cyc();
    check("t3_post_valid", out_valid, 0);
    check("t3_post_sum", out_sum, 0);
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 15'd5; in_y = 12'd7;
    cyc();
    in_valid = 1'b0;
    check("t3_lat1", out_valid, 0);
    cyc();
    check("t3_lat2_valid", out_valid, 1);
    check("t3_lat2_sum", out_sum, 12);
    cyc();

    // 4: clr while full with a pair on offer
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 15'd10; in_y = 12'd20;
    cyc();
    in_x = 15'd30; in_y = 12'd40;
    cyc();
    in_x = 15'd50; in_y = 12'd60;
    out_ready = 1'b1;
    clr = 1'b1;
    #1;
    check("t4_clr_in_ready", in_ready, 0);
    exp_q.delete();
    cyc();
    clr = 1'b0;
    in_valid = 1'b0;
    check("t4_flush_valid", out_valid, 0);
    check("t4_add_x_kept", add_x, 30);
    check("t4_add_y_kept", add_y, 40);
    cyc();
    check("t4_s1_empty", out_valid, 0);
    cyc();
    check("t4_not_accepted", out_valid, 0);

    // 5: random stream with 30% output readiness
    for (int i = 0; i < 10000; i++)
      send(XW'($urandom_range(0, 32767)), YW'($urandom_range(0, 4095)), 30);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    check("t5_drained", exp_q.size(), 0);

`ifdef CLA_STAGE_STATS_EN
    // 6: saturating statistics
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("t6_txn_zero", stat_txn, 0);
    for (int i = 0; i < 20; i++) send(15'd32767, 12'd4095, 100);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cyc();
    check("t6_cout_sat", stat_cout, 15);
    check("t6_txn_sat", stat_txn, 15);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("t6_cout_clr", stat_cout, 0);
    check("t6_txn_clr", stat_txn, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
